// File: rtl/dom_rand_feeder.sv
// LFSR-based randomness source that feeds Z (remask) and B (blind) words
// to a DOM multiplier, with seed load, warmup and reseed request.
module dom_rand_feeder #(
    parameter int unsigned SHARES          = 2,
    parameter int unsigned WARMUP_CYCLES   = 16,
    parameter logic [31:0] RESEED_INTERVAL = 32'd1024
) (
    input  logic                              ClkxCI,
    input  logic                              RstxBI,
    input  logic [63:0]                       SeedxDI,
    input  logic                              SeedValidxSI,
    input  logic                              EnxSI,
    output logic [2*SHARES*(SHARES-1)-1:0]    ZxDO,
    output logic [4*SHARES-1:0]               BxDO,
    output logic                              ValidxSO,
    output logic                              ReseedReqxSO
);

    localparam int unsigned ZW = 2 * SHARES * (SHARES - 1);
    localparam int unsigned BW = 4 * SHARES;
    localparam int unsigned R  = ZW + BW;
    localparam logic [7:0]  WU = 8'(WARMUP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     s_q, s_d, s_adv;
    logic [ZW-1:0]   z_q, z_d;
    logic [BW-1:0]   b_q, b_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [31:0]     cnt_q, cnt_d, cnt_inc;
    logic            req_q, req_d;

    // One advance = R LFSR steps, so each word uses fresh state bits.
    function automatic logic [63:0] advance(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < int'(R); i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    always_comb begin
        s_adv   = advance(s_q);
        cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        state_d = state_q;
        s_d     = s_q;
        z_d     = z_q;
        b_d     = b_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        if (SeedValidxSI) begin
            state_d = WARMUP;
            s_d     = (SeedxDI == 64'd0) ? 64'h1 : SeedxDI;
            z_d     = '0;
            b_d     = '0;
            wcnt_d  = '0;
            cnt_d   = '0;
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                WARMUP: begin
                    s_d = s_adv;
                    if (wcnt_q == WU) begin
                        z_d     = s_adv[ZW-1:0];
                        b_d     = s_adv[R-1:ZW];
                        state_d = RUN;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
                RUN: begin
                    if (EnxSI) begin
                        s_d   = s_adv;
                        z_d   = s_adv[ZW-1:0];
                        b_d   = s_adv[R-1:ZW];
                        cnt_d = cnt_inc;
                        if (cnt_inc >= RESEED_INTERVAL) begin
                            req_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state_q <= IDLE;
            s_q     <= 64'h1;
            z_q     <= '0;
            b_q     <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            z_q     <= z_d;
            b_q     <= b_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    assign ZxDO         = z_q;
    assign BxDO         = b_q;
    assign ValidxSO     = (state_q == RUN);
    assign ReseedReqxSO = req_q;

endmodule
